// File: rtl/uart_rx_ctrl_if.sv
// Bus-side interface of the UART RX controller: MIPS data-bus strobes, read data and interrupt.
// master = CPU/bus side, slave = the controller.
interface uart_rx_ctrl_if;
  logic [31:0] addr_i;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  modport master (output addr_i, rd_en_i, wr_en_i, wdata_i, input rdata_o, irq_o);
  modport slave  (input addr_i, rd_en_i, wr_en_i, wdata_i, output rdata_o, irq_o);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: receiver flag handshake, byte FIFO, data/status/control registers, level irq.
// Optional idle timeout flag is built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int          NBIT           = 8,
  parameter int          DEPTH          = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h10010028,
  parameter int          TIMEOUT_CYCLES = 52080
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_flag_i,
  input  logic [NBIT-1:0] rx_data_i,
  output logic            clr_rx_flag_o,
  uart_rx_ctrl_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {WAIT_FLAG, CAPTURE, CLEAR, WAIT_DROP} state_e;

  state_e state_q;
  logic   clr_q;

  // Clear output is registered: it is low exactly while the FSM sits in CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_FLAG;
      clr_q   <= 1'b1;
    end else begin
      clr_q <= 1'b1;
      case (state_q)
        WAIT_FLAG: if (rx_flag_i) state_q <= CAPTURE;
        CAPTURE: begin
          state_q <= CLEAR;
          clr_q   <= 1'b0;
        end
        CLEAR:     state_q <= WAIT_DROP;
        WAIT_DROP: begin
          if (rx_flag_i) begin
            state_q <= CLEAR;
            clr_q   <= 1'b0;
          end else begin
            state_q <= WAIT_FLAG;
          end
        end
        default:   state_q <= WAIT_FLAG;
      endcase
    end
  end

  logic [NBIT-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            timeout_q;

  logic sel_data, sel_stat, sel_ctrl, rd_op, wr_ctrl;
  logic empty, full, pop, flush, push_req, push, ovr_set;
  logic [31:0] data_word, stat_word, ctrl_word;

  assign sel_data = (bus.addr_i == BASE_ADDR);
  assign sel_stat = (bus.addr_i == BASE_ADDR + 32'd4);
  assign sel_ctrl = (bus.addr_i == BASE_ADDR + 32'd8);
  // A write wins over a simultaneous read, so such a read never pops.
  assign rd_op    = bus.rd_en_i & ~bus.wr_en_i;
  assign wr_ctrl  = bus.wr_en_i & sel_ctrl;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = rd_op & sel_data & ~empty;
  assign flush    = wr_ctrl & bus.wdata_i[1];
  assign push_req = (state_q == CAPTURE);
  assign push     = push_req & ~flush & (~full | pop);
  assign ovr_set  = push_req & ~flush & full & ~pop;

  always_comb begin
    data_word = '0;
    if (!empty) begin
      data_word[31]         = 1'b1;
      data_word[NBIT-1:0]   = mem_q[rptr_q];
    end
    stat_word             = '0;
    stat_word[0]          = ~empty;
    stat_word[1]          = full;
    stat_word[2]          = overrun_q;
    stat_word[3]          = timeout_q;
    stat_word[8 +: CW]    = count_q;
    ctrl_word             = '0;
    ctrl_word[0]          = irq_en_q;
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    irq_en_d  = irq_en_q;
    rdata_d   = rdata_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    if (wr_ctrl) begin
      irq_en_d = bus.wdata_i[0];
      if (bus.wdata_i[2]) overrun_d = 1'b0;
    end
    if (ovr_set) overrun_d = 1'b1;
    if (bus.rd_en_i) begin
      if (bus.wr_en_i)   rdata_d = '0;
      else if (sel_data) rdata_d = data_word;
      else if (sel_stat) rdata_d = stat_word;
      else if (sel_ctrl) rdata_d = ctrl_word;
      else               rdata_d = '0;
    end
    irq_d = irq_en_q & (~empty | overrun_q | timeout_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rx_data_i;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_d;

  // Flag is set only on the step that reaches the limit, so a clear sticks while saturated.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push | pop | flush | empty)            idle_d = '0;
    else if (idle_q != TW'(TIMEOUT_CYCLES))    idle_d = idle_q + 1'b1;
    if (wr_ctrl & bus.wdata_i[3])              timeout_d = 1'b0;
    if (idle_d == TW'(TIMEOUT_CYCLES) && idle_q != TW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_timeout;
  assign timeout_q      = 1'b0;
  assign unused_timeout = bus.wdata_i[3] ^ (TIMEOUT_CYCLES != 0);
`endif

  logic unused_wdata;
  assign unused_wdata  = ^bus.wdata_i[31:4];

  assign clr_rx_flag_o = clr_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.irq_o     = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: handshake timing, FIFO order/full/overrun, flush, irq, bus decode.
// Status checks mask bit3 except in the dedicated timeout section.
module tb_uart_rx_ctrl;
  localparam logic [31:0] BASE   = 32'h10010028;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_flag = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_rx_flag;
  int         tests = 0;
  int         fails = 0;
  logic [31:0] rd;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.NBIT(8), .DEPTH(4), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .rx_flag_i(rx_flag), .rx_data_i(rx_data),
    .clr_rx_flag_o(clr_rx_flag), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr_i  = a;
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.wr_en_i = 1'b1;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic check_stat(input string tag, input logic [31:0] exp);
    logic [31:0] s;
    bus_read(A_STAT, s);
    check(tag, s & ~32'h8, exp);
  endtask

  task automatic check_data(input string tag, input logic [31:0] exp);
    logic [31:0] s;
    bus_read(A_DATA, s);
    check(tag, s, exp);
  endtask

  // Receiver model: raise the flag, drop it once the clear pulse is seen.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_flag = 1'b1;
    while (clr_rx_flag !== 1'b0 && n < 5) begin
      tick();
      n++;
    end
    check("send_clr_pulse", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    bus.addr_i  = '0;
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.wdata_i = '0;

    repeat (3) tick();
    check("rst_clr", 32'(clr_rx_flag), 32'h1);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_irq", 32'(bus.irq_o), 32'h0);
    reset = 1'b0;
    tick();
    bus_read(A_STAT, rd);
    check("rst_status", rd, 32'h0);

    // single byte: latency and pulse width of the clear
    rx_data = 8'hA5;
    rx_flag = 1'b1;
    n = 0;
    while (clr_rx_flag !== 1'b0 && n < 5) begin
      tick();
      n++;
    end
    check("t1_clr_latency", 32'(n), 32'd2);
    rx_flag = 1'b0;
    tick();
    check("t1_clr_one_cycle", 32'(clr_rx_flag), 32'h1);
    tick();
    check_stat("t1_status", 32'h00000101);
    check_data("t1_data", 32'h800000A5);
    check_stat("t1_status_empty", 32'h0);

    // overrun on the fifth byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check_stat("t2_full_ovr", 32'h00000407);
    for (int i = 1; i <= 4; i++) check_data("t2_order", 32'h80000000 | 32'(i));
    check_data("t2_empty_read", 32'h0);
    check_stat("t2_ovr_only", 32'h00000004);
    bus_write(A_CTRL, 32'h4);
    check_stat("t2_ovr_cleared", 32'h0);

    // full FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
    check_stat("t3_full", 32'h00000403);
    rx_data = 8'h15;
    rx_flag = 1'b1;
    tick();
    bus_read(A_DATA, rd);
    check("t3_pop", rd, 32'h80000011);
    check("t3_clr", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
    check_stat("t3_still_full", 32'h00000403);
    for (int i = 0; i < 4; i++) check_data("t3_order", 32'h80000012 + 32'(i));
    check_stat("t3_empty", 32'h0);

    // interrupt
    bus_write(A_CTRL, 32'hF);
    tick();
    check("t4_irq_empty", 32'(bus.irq_o), 32'h0);
    rx_data = 8'h3C;
    rx_flag = 1'b1;
    tick();
    tick();
    check("t4_irq_at_push", 32'(bus.irq_o), 32'h0);
    rx_flag = 1'b0;
    tick();
    check("t4_irq_after_push", 32'(bus.irq_o), 32'h1);
    tick();
    check_data("t4_data", 32'h8000003C);
    tick();
    check("t4_irq_after_pop", 32'(bus.irq_o), 32'h0);
    bus_write(A_CTRL, 32'h0);

    // flush, then flag held high across the clear pulse
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    check_stat("t5_three", 32'h00000301);
    bus_write(A_CTRL, 32'h6);
    check_stat("t5_flushed", 32'h0);
    check("t5_irq", 32'(bus.irq_o), 32'h0);
    rx_data = 8'h77;
    rx_flag = 1'b1;
    tick();
    tick();
    check("t5_clr_first", 32'(clr_rx_flag), 32'h0);
    tick();
    check("t5_clr_high", 32'(clr_rx_flag), 32'h1);
    tick();
    check("t5_clr_repulse", 32'(clr_rx_flag), 32'h0);
    tick();
    tick();
    check("t5_clr_repulse2", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
    check_stat("t5_one_push", 32'h00000101);
    check_data("t5_data", 32'h80000077);
    check_stat("t5_empty", 32'h0);

    // flush in the push cycle discards the byte
    rx_data = 8'h66;
    rx_flag = 1'b1;
    tick();
    bus_write(A_CTRL, 32'h2);
    check("t6_clr", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
    check_stat("t6_flush_beats_push", 32'h0);

    // overrun clear colliding with a new overrun
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
    rx_data = 8'h35;
    rx_flag = 1'b1;
    tick();
    bus_write(A_CTRL, 32'h4);
    check("t7_clr", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
    check_stat("t7_ovr_set_wins", 32'h00000407);
    bus_write(A_CTRL, 32'h6);
    check_stat("t7_cleared", 32'h0);

    // bus decode: rd+wr collision, hold, unmapped
    send_byte(8'h5A);
    check_stat("t8_status", 32'h00000101);
    bus.addr_i  = A_CTRL;
    bus.wdata_i = 32'h1;
    bus.rd_en_i = 1'b1;
    bus.wr_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    check("t8_rdwr_zero", bus.rdata_o, 32'h0);
    bus_read(A_CTRL, rd);
    check("t8_ctrl", rd, 32'h1);
    tick();
    tick();
    check("t8_hold", bus.rdata_o, 32'h1);
    bus_read(BASE + 32'd12, rd);
    check("t8_unmapped", rd, 32'h0);
    bus_write(A_CTRL, 32'h0);

    // reset in the middle of a handshake
    rx_data = 8'h99;
    rx_flag = 1'b1;
    tick();
    tick();
    check("t9_clr_before", 32'(clr_rx_flag), 32'h0);
    reset = 1'b1;
    tick();
    check("t9_reset_clr", 32'(clr_rx_flag), 32'h1);
    check("t9_reset_rdata", bus.rdata_o, 32'h0);
    reset = 1'b0;
    n = 0;
    while (clr_rx_flag !== 1'b0 && n < 5) begin
      tick();
      n++;
    end
    check("t9_recapture_clr", 32'(clr_rx_flag), 32'h0);
    rx_flag = 1'b0;
    tick();
    tick();
    check_stat("t9_status", 32'h00000101);
    check_data("t9_data", 32'h80000099);
    check_stat("t9_empty", 32'h0);

    // timeout flag
    send_byte(8'h42);
    repeat (12) tick();
    bus_read(A_STAT, rd);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    check("to_set", rd, 32'h00000109);
    bus_write(A_CTRL, 32'h8);
    bus_read(A_STAT, rd);
    check("to_cleared", rd, 32'h00000101);
`else
    check("to_absent", rd, 32'h00000101);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
